// File: rtl/dma_resp_pkg.sv
// Shared types and constants for the dma_mem_responder block.
//   count_t    : transfer size / line counter (default SIZE_WIDTH)
//   line_t     : one cache line of data (default DATA_WIDTH)
//   line_idx_t : RAM line index (default MEM_LINES_LOG2)
//   rd_state_e / wr_state_e : channel FSM states
//   LINE_SHIFT : byte address -> line index shift (64-byte lines)
package dma_resp_pkg;
   localparam int PKG_DATA_WIDTH     = 512;
   localparam int PKG_SIZE_WIDTH     = 43;
   localparam int PKG_MEM_LINES_LOG2 = 10;
   localparam int LINE_SHIFT         = 6;

   typedef logic [PKG_SIZE_WIDTH-1:0]     count_t;
   typedef logic [PKG_DATA_WIDTH-1:0]     line_t;
   typedef logic [PKG_MEM_LINES_LOG2-1:0] line_idx_t;

   typedef enum logic [1:0] {
      RD_IDLE   = 2'd0,
      RD_ACTIVE = 2'd1,
      RD_DONE   = 2'd2
   } rd_state_e;

   typedef enum logic [1:0] {
      WR_IDLE   = 2'd0,
      WR_ACTIVE = 2'd1,
      WR_DONE   = 2'd2
   } wr_state_e;
endpackage

// File: rtl/dma_resp_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
//   clk, rst_n : clock, async active-low reset (flushes and zeroes storage)
//   i_push     : write i_data (ignored when full)
//   i_pop      : drop the head entry (ignored when empty)
//   o_data     : current head entry, straight from the storage registers
//   o_empty    : no entry held
//   o_count    : number of entries held (0..DEPTH)
module dma_resp_fifo #(
   parameter int WIDTH = 512,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push = i_push && (r_count != CW'(DEPTH));
   assign w_pop  = i_pop && (r_count != '0);

   // Storage is reset so the head reads as zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= r_wptr + AW'(1);
         end
         if (w_pop) r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rptr];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
endmodule

// File: rtl/dma_mem_responder.sv
// Host-side dma_if responder backed by an internal line-wide RAM.
//   clk, rst_n                 : clock, async active-low reset
//   rd_addr/rd_size/rd_go      : start a read of rd_size lines at byte rd_addr
//   rd_en, rd_data, empty      : show-ahead read FIFO pop / head / empty
//   rd_done                    : every requested line has been popped
//   wr_addr/wr_size/wr_go      : start a write of wr_size lines at byte wr_addr
//   wr_en, wr_data, full       : write FIFO push / data / back-pressure
//   wr_done                    : every line has been committed to RAM
//   bd_we/bd_addr/bd_data      : backdoor line write, wins the RAM port
module dma_mem_responder
   import dma_resp_pkg::*;
#(
   parameter int DATA_WIDTH     = 512,
   parameter int ADDR_WIDTH     = 64,
   parameter int SIZE_WIDTH     = 43,
   parameter int MEM_LINES_LOG2 = 10,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ADDR_WIDTH-1:0]     rd_addr,
   input  logic [SIZE_WIDTH-1:0]     rd_size,
   input  logic                      rd_go,
   input  logic                      rd_en,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic                      empty,
   output logic                      rd_done,
   input  logic [ADDR_WIDTH-1:0]     wr_addr,
   input  logic [SIZE_WIDTH-1:0]     wr_size,
   input  logic                      wr_go,
   input  logic                      wr_en,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   output logic                      full,
   output logic                      wr_done,
   input  logic                      bd_we,
   input  logic [MEM_LINES_LOG2-1:0] bd_addr,
   input  logic [DATA_WIDTH-1:0]     bd_data
);
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int LINES = 1 << MEM_LINES_LOG2;

   // read channel
   rd_state_e                 r_rd_state;
   logic [MEM_LINES_LOG2-1:0] r_rd_line;
   logic [SIZE_WIDTH-1:0]     r_rd_size;
   logic [SIZE_WIDTH-1:0]     r_rd_issued;
   logic [SIZE_WIDTH-1:0]     r_rd_popped;
   logic                      r_rd_vld;
   logic                      r_rd_done;
   // write channel
   wr_state_e                 r_wr_state;
   logic [MEM_LINES_LOG2-1:0] r_wr_line;
   logic [SIZE_WIDTH-1:0]     r_wr_size;
   logic [SIZE_WIDTH-1:0]     r_wr_acc;
   logic [SIZE_WIDTH-1:0]     r_wr_com;
   logic                      r_wr_done;
   // RAM and arbiter
   logic [DATA_WIDTH-1:0]     r_mem [LINES];
   logic [DATA_WIDTH-1:0]     r_ram_q;
   logic                      r_rr;  // 1: writes win the next contested cycle

   logic [CW-1:0]             w_rf_count;
   logic [CW-1:0]             w_wf_count;
   logic [CW-1:0]             w_rd_occ;
   logic                      w_wf_empty;
   logic [DATA_WIDTH-1:0]     w_wf_data;
   logic                      w_rd_req;
   logic                      w_wr_req;
   logic                      w_rd_gnt;
   logic                      w_wr_gnt;
   logic                      w_contend;
   logic                      w_rd_pop;
   logic                      w_wr_acc;
   logic                      w_unused;

   // Only the line-index slice of the byte addresses is used.
   assign w_unused = ^{rd_addr, wr_addr};

   dma_resp_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_rd_vld),
      .i_data  (r_ram_q),
      .i_pop   (rd_en),
      .o_data  (rd_data),
      .o_empty (empty),
      .o_count (w_rf_count)
   );

   dma_resp_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_wr_acc),
      .i_data  (wr_data),
      .i_pop   (w_wr_gnt),
      .o_data  (w_wf_data),
      .o_empty (w_wf_empty),
      .o_count (w_wf_count)
   );

   // A read in flight already owns a FIFO slot, so it counts toward occupancy.
   assign w_rd_occ = w_rf_count + CW'(r_rd_vld);
   assign w_rd_req = (r_rd_state == RD_ACTIVE) && (r_rd_issued < r_rd_size) &&
                     (w_rd_occ < CW'(FIFO_DEPTH));
   assign w_wr_req = (r_wr_state == WR_ACTIVE) && !w_wf_empty;

   assign w_contend = !bd_we && w_rd_req && w_wr_req;
   assign w_rd_gnt  = !bd_we && w_rd_req && (!w_wr_req || !r_rr);
   assign w_wr_gnt  = !bd_we && w_wr_req && (!w_rd_req || r_rr);

   assign w_rd_pop = rd_en && !empty;
   assign full     = (r_wr_state != WR_ACTIVE) || (w_wf_count == CW'(FIFO_DEPTH)) ||
                     (r_wr_acc == r_wr_size);
   assign w_wr_acc = wr_en && !full;

   assign rd_done = r_rd_done;
   assign wr_done = r_wr_done;

   // RAM contents survive reset; the backdoor pre-empts both channels.
   always_ff @(posedge clk) begin
      if (bd_we)         r_mem[bd_addr]   <= bd_data;
      else if (w_wr_gnt) r_mem[r_wr_line] <= w_wf_data;
      if (w_rd_gnt)      r_ram_q          <= r_mem[r_rd_line];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_rr <= 1'b0;
      else if (w_contend) r_rr <= ~r_rr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_state  <= RD_IDLE;
         r_rd_line   <= '0;
         r_rd_size   <= '0;
         r_rd_issued <= '0;
         r_rd_popped <= '0;
         r_rd_vld    <= 1'b0;
         r_rd_done   <= 1'b0;
      end else begin
         r_rd_vld <= w_rd_gnt;
         case (r_rd_state)
            RD_IDLE, RD_DONE: begin
               if (rd_go) begin
                  r_rd_line   <= rd_addr[LINE_SHIFT +: MEM_LINES_LOG2];
                  r_rd_size   <= rd_size;
                  r_rd_issued <= '0;
                  r_rd_popped <= '0;
                  if (rd_size == '0) begin
                     r_rd_state <= RD_DONE;
                     r_rd_done  <= 1'b1;
                  end else begin
                     r_rd_state <= RD_ACTIVE;
                     r_rd_done  <= 1'b0;
                  end
               end
            end
            RD_ACTIVE: begin
               if (w_rd_gnt) begin
                  r_rd_line   <= r_rd_line + MEM_LINES_LOG2'(1);
                  r_rd_issued <= r_rd_issued + SIZE_WIDTH'(1);
               end
               if (w_rd_pop) begin
                  r_rd_popped <= r_rd_popped + SIZE_WIDTH'(1);
                  if (r_rd_popped + SIZE_WIDTH'(1) == r_rd_size) begin
                     r_rd_state <= RD_DONE;
                     r_rd_done  <= 1'b1;
                  end
               end
            end
            default: r_rd_state <= RD_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_state <= WR_IDLE;
         r_wr_line  <= '0;
         r_wr_size  <= '0;
         r_wr_acc   <= '0;
         r_wr_com   <= '0;
         r_wr_done  <= 1'b0;
      end else begin
         case (r_wr_state)
            WR_IDLE, WR_DONE: begin
               if (wr_go) begin
                  r_wr_line <= wr_addr[LINE_SHIFT +: MEM_LINES_LOG2];
                  r_wr_size <= wr_size;
                  r_wr_acc  <= '0;
                  r_wr_com  <= '0;
                  if (wr_size == '0) begin
                     r_wr_state <= WR_DONE;
                     r_wr_done  <= 1'b1;
                  end else begin
                     r_wr_state <= WR_ACTIVE;
                     r_wr_done  <= 1'b0;
                  end
               end
            end
            WR_ACTIVE: begin
               if (w_wr_acc) r_wr_acc <= r_wr_acc + SIZE_WIDTH'(1);
               if (w_wr_gnt) begin
                  r_wr_line <= r_wr_line + MEM_LINES_LOG2'(1);
                  r_wr_com  <= r_wr_com + SIZE_WIDTH'(1);
                  if (r_wr_com + SIZE_WIDTH'(1) == r_wr_size) begin
                     r_wr_state <= WR_DONE;
                     r_wr_done  <= 1'b1;
                  end
               end
            end
            default: r_wr_state <= WR_IDLE;
         endcase
      end
   end
endmodule

// File: doc/dma_mem_responder.md
# dma_mem_responder

Host-side responder for the `dma_if` protocol: it implements the end of the interface that AFU logic drives as `dma_if.peripheral`. It serves the read and write channels from an internal cache-line-wide RAM instead of CPU memory. The block is the standard simulation and on-chip stand-in for the real DMA/HAL. It lets `afu`, `mem_ctrl` and CPU integrations run loopback and memory tests without host software.

## Interface
Parameters:
- `DATA_WIDTH`, 512: cache-line width in bits.
- `ADDR_WIDTH`, 64: virtual byte-address width.
- `SIZE_WIDTH`, 43: transfer-size width, in cache lines.
- `MEM_LINES_LOG2`, 10: log2 of the number of RAM lines.
- `FIFO_DEPTH`, 8: entries per channel FIFO; must be a power of two, at least 2.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rd_addr`  in  ADDR_WIDTH  starting byte address of the read transfer.
- `rd_size`  in  SIZE_WIDTH  number of lines to read.
- `rd_go`  in  1  starts the read transfer.
- `rd_en`  in  1  pops the line currently on `rd_data`.
- `rd_data`  out  DATA_WIDTH  head of the read FIFO (show-ahead).
- `empty`  out  1  read FIFO holds no line.
- `rd_done`  out  1  all `rd_size` lines have been popped.
- `wr_addr`  in  ADDR_WIDTH  starting byte address of the write transfer.
- `wr_size`  in  SIZE_WIDTH  number of lines to write.
- `wr_go`  in  1  starts the write transfer.
- `wr_en`  in  1  pushes `wr_data`.
- `wr_data`  in  DATA_WIDTH  line to write.
- `full`  out  1  write FIFO cannot accept a line.
- `wr_done`  out  1  all `wr_size` lines have been committed to RAM.
- `bd_we`  in  1  backdoor RAM write, used for bench preload.
- `bd_addr`  in  MEM_LINES_LOG2  backdoor line index.
- `bd_data`  in  DATA_WIDTH  backdoor write data.

## Operation
- **Address mapping:** line index = `addr[MEM_LINES_LOG2+5:6]`. Upper bits are dropped. The index increments by 1 per line and wraps modulo 2^MEM_LINES_LOG2.
- **Read channel FSM** (RD_IDLE, RD_ACTIVE, RD_DONE):
  - `rd_go`=1 in RD_IDLE or RD_DONE: latch `rd_addr` and `rd_size`, clear the counters, go to RD_ACTIVE.
  - `rd_go` in RD_ACTIVE is ignored.
  - RD_ACTIVE issues a RAM read while issued < size and (FIFO count + in-flight) < FIFO_DEPTH. Returned data is pushed into the read FIFO.
  - Popped == size moves the FSM to RD_DONE. `rd_done`=1 in RD_DONE only.
  - `rd_en` while `empty`=1 is ignored, with no pointer change.
- **Write channel FSM** (WR_IDLE, WR_ACTIVE, WR_DONE):
  - `wr_go` in WR_IDLE or WR_DONE: latch `wr_addr` and `wr_size`, go to WR_ACTIVE.
  - `full`=1 outside WR_ACTIVE, and in WR_ACTIVE when the FIFO count == FIFO_DEPTH or accepted == size.
  - `wr_en` while `full`=1 is dropped.
  - The write FIFO head is written to RAM when granted. Committed == size moves the FSM to WR_DONE. `wr_done`=1 in WR_DONE.
- **Size 0:** a go with size 0 moves the channel straight to its DONE state; no RAM access is made.
- **RAM port arbitration** (single port):
  - `bd_we` has the highest priority.
  - Read and write requests are otherwise arbitrated round-robin. The last-winner flag toggles only on a contested grant.
- **Simultaneous `rd_go`/`wr_go`:** both channels start. A read of a line still pending write returns the old RAM contents; no ordering is enforced between channels.
- **Reset:**
  - Both FSMs go to IDLE, FIFOs are flushed, counters clear, the round-robin flag is set to 0 (reads first).
  - RAM contents are not reset.
  - Reset values: `empty`=1, `rd_done`=0, `full`=1, `wr_done`=0, `rd_data`=0.
  - Reset asserted mid-transfer abandons the transfer; no partial `done` is produced.

## Timing
- RAM read latency: 1 cycle.
- `rd_go` sampled at cycle T, uncontested: first RAM read at T+1, FIFO push at T+2, `empty`=0 at T+3.
- Sustained read throughput: 1 line/cycle with `rd_en` held high and no write contention.
- `rd_done` rises the cycle after the final pop.
- `wr_go` at T: `full` falls at T+1.
- A line pushed at cycle W is committed no earlier than W+1.
- `wr_done` rises the cycle after the final commit.
- All outputs are registered except `rd_data`/`empty`, which come from FIFO registers, and `full`, which is FSM/counter decode.

## Structure
- **Package `dma_resp_pkg`:** `count_t` (SIZE_WIDTH), `line_t` (DATA_WIDTH), `line_idx_t`, the read and write FSM state enums, and the byte-to-line shift constant (6).
- **Sub-module `dma_resp_fifo`:** synchronous show-ahead FIFO with count output. It is instantiated once per channel.
- The top level holds the two FSMs, the arbiter and the RAM array.

## Test plan
- Backdoor-load lines 0..15 with value i. `rd_addr`=0x0, `rd_size`=16, `rd_en` held high → `rd_data` = 0..15 in order, `empty`=0 by T+3, `rd_done`=1 one cycle after the 16th pop.
- Loopback (`rd_addr`=0x0, `wr_addr`=0x4000, size=64, `wr_en`=`rd_en`=~`empty`&~`full`) → `wr_done`=1; a read-back from 0x4000 returns 0..63.
- Wrap: `rd_addr`=(2^MEM_LINES_LOG2−2)<<6, size=4 → data from lines 1022, 1023, 0, 1.
- Write back-pressure: `wr_en` held for 20 cycles with reads contending → `full` observed high, exactly `wr_size` lines committed, extra `wr_en` dropped.
- `rd_size`=0 → `rd_done`=1 at T+1, `empty` stays 1, no RAM access; a second `rd_go` while active is ignored.
- `rst_n` pulsed low mid-transfer → all outputs at their reset values immediately; RAM contents intact; a new transfer completes normally.
